// File: rtl/ripple_seq_pkg.sv
// ripple_seq_pkg: shared definitions for the nibble-serial adder sequencer.
//   state_t  : sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W : width of the shared ripple adder slice (4)
package ripple_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_adder.sv
// ripple_adder: 4-bit ripple-carry adder, the single arithmetic resource
// that the sequencer time-shares across nibbles.
//   sum  [3:0] out : a + b + cin, low 4 bits
//   cout       out : carry out of bit 3
//   a, b [3:0] in  : addends
//   cin        in  : carry in to bit 0
module ripple_adder
    import ripple_seq_pkg::*;
(
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: adds two WIDTH-bit operands one nibble per clock,
// LSB nibble first, through one shared 4-bit ripple_adder. The carry out of
// each nibble is registered and fed back as the carry in of the next.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b [WIDTH-1:0]    : operands, captured on the accept edge only
//   cin                 : initial carry into nibble 0
//   op                  : 0 add, 1 subtract (only with RIPPLE_SEQ_SUB_EN)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum [WIDTH-1:0]     : result, stable throughout DONE
//   cout                : carry out of bit WIDTH-1 (1 = no borrow on subtract)
//
// Build option: define RIPPLE_SEQ_SUB_EN to add the op port and subtract
// support (B latched inverted, initial carry forced to 1).
//
// WIDTH must be a multiple of 4 and at least 4.
module ripple_add_sequencer
    import ripple_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RIPPLE_SEQ_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t                state;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [WIDTH-1:0]      sum_q;
    logic                  carry_q;
    logic [CW-1:0]         idx;

    logic [WIDTH-1:0]      b_in;
    logic                  c_in;
    logic [NIBBLE_W-1:0]   nib_a;
    logic [NIBBLE_W-1:0]   nib_b;
    logic [NIBBLE_W-1:0]   nib_sum;
    logic                  nib_cout;

    // Two's-complement subtract reuses the adder: a + ~b + 1.
`ifdef RIPPLE_SEQ_SUB_EN
    assign b_in = op ? ~b : b;
    assign c_in = op | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign nib_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx*NIBBLE_W +: NIBBLE_W];

    ripple_adder u_adder (
        .sum  (nib_sum),
        .cout (nib_cout),
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry_q                         <= nib_cout;
                    if (idx == CW'(NIB - 1))
                        state <= DONE;
                    else
                        idx <= idx + 1'b1;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode registered state only, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_ripple_add_sequencer.sv
module tb_ripple_add_sequencer;

    localparam int W   = 16;
    localparam int NIB = W / 4;
`ifdef RIPPLE_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, cout, op;

    logic         in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]   a4, b4, sum4;
    logic         cin4, cout4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ripple_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RIPPLE_SEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    ripple_add_sequencer #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef RIPPLE_SEQ_SUB_EN
        .op        (1'b0),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a transaction is accepted when idle, its result is the
    // plain arithmetic sum (or difference), visible NIB cycles later, and held
    // until the consumer takes it.
    logic         m_rdy = 1'b1, m_vld = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rdy = 1'b1; m_vld = 1'b0; m_left = 0; m_sum = '0; m_cout = 1'b0;
        end else if (m_rdy) begin
            if (in_valid) begin
                if (SUB_EN && op) begin
                    m_sum  = a - b;
                    m_cout = (a >= b);
                end else begin
                    m_sum  = W'(int'(a) + int'(b) + int'(cin));
                    m_cout = (int'(a) + int'(b) + int'(cin)) >= (1 << W);
                end
                m_rdy  = 1'b0;
                m_left = NIB;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_vld = 1'b1;
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", 32'(in_ready), 32'(m_rdy));
            check("cmp_out_valid", 32'(out_valid), 32'(m_vld));
            if (m_vld) begin
                check("cmp_sum", 32'(sum), 32'(m_sum));
                check("cmp_cout", 32'(cout), 32'(m_cout));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic to, input int hold,
                          input bit pre_rdy, output logic [W-1:0] rs,
                          output logic rc, output int lat);
        int cnt;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; op = to; in_valid = 1'b1; out_ready = pre_rdy;
        @(posedge clk); #1;
        // Operands change after accept; the result must not follow them.
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (out_valid) break;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
        lat = cnt - 1;
        rs  = sum;
        rc  = cout;
        if (!pre_rdy && hold > 0) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_sum", 32'(sum), 32'(rs));
                check("hold_cout", 32'(cout), 32'(rc));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    task automatic abort_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int k);
        int stale;
        @(posedge clk); #1;
        a = ta; b = tb; cin = 1'b0; op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < k; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < NIB + 3; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("abort_no_stale", 32'(stale), 32'd0);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int cnt;
        logic [4:0] exp;
        exp = 5'(ta) + 5'(tb) + 5'(tc);
        @(posedge clk); #1;
        check("w4_in_ready", 32'(in_ready4), 32'd1);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt++;
            if (out_valid4) break;
        end
        check("w4_latency", 32'(cnt - 1), 32'd1);
        check("w4_sum", 32'(sum4), 32'(exp[3:0]));
        check("w4_cout", 32'(cout4), 32'(exp[4]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        logic         to;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        run_op(16'h0001, 16'h000A, 1'b0, 1'b0, 0, 1'b0, rs, rc, lat);
        check("basic_sum", 32'(rs), 32'h000B);
        check("basic_cout", 32'(rc), 32'd0);
        check("basic_latency", 32'(lat), 32'(NIB));
        check("model_basic", 32'(m_sum), 32'h000B);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, rs, rc, lat);
        check("carry_sum", 32'(rs), 32'h0000);
        check("carry_cout", 32'(rc), 32'd1);
        check("model_carry", 32'({m_cout, m_sum}), 32'h10000);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 5, 1'b0, rs, rc, lat);
        check("ffff_sum", 32'(rs), 32'hFFFE);
        check("ffff_cout", 32'(rc), 32'd1);

        abort_op(16'h1234, 16'h1111, 2);

`ifdef RIPPLE_SEQ_SUB_EN
        run_op(16'h0009, 16'h0004, 1'b0, 1'b1, 0, 1'b0, rs, rc, lat);
        check("sub_sum", 32'(rs), 32'h0005);
        check("sub_cout", 32'(rc), 32'd1);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 1, 1'b0, rs, rc, lat);
        check("borrow_sum", 32'(rs), 32'hFFFF);
        check("borrow_cout", 32'(rc), 32'd0);
`endif

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                abort_op(W'($urandom), W'($urandom), $urandom_range(1, NIB + 3));
            end else begin
                to = SUB_EN ? 1'($urandom) : 1'b0;
                run_op(W'($urandom), W'($urandom), 1'($urandom), to,
                       $urandom_range(0, 3), 1'($urandom), rs, rc, lat);
                check("rand_latency", 32'(lat), 32'(NIB));
            end
        end

        run4(4'd9, 4'd4, 1'b1);
        check("w4_directed_sum", 32'(sum4), 32'd14);
        for (int n = 0; n < 12; n++)
            run4(4'($urandom), 4'($urandom), 1'($urandom));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
